// File: rtl/i2c_regbank_target_if.sv
// Pad-side I2C signals of the register-bank target.
// The master modport is the bus/pad side; the slave modport is the target.
interface i2c_regbank_target_if;
    logic sda_in;
    logic scl_in;
    logic sda_out;
    logic sda_oe;

    modport master (output sda_in, output scl_in, input sda_out, input sda_oe);
    modport slave  (input sda_in, input scl_in, output sda_out, output sda_oe);
endinterface

// File: rtl/i2c_regbank_target.sv
// I2C target with a byte register bank, wrapping auto-increment pointer and per-byte write strobe.
// Define I2C_GLITCH_FILTER_EN to add a 3-sample majority filter on SDA/SCL after the synchronisers.
module i2c_regbank_target #(
    parameter logic [6:0] I2C_ADDR    = 7'h70,
    parameter int         NUM_REGS    = 8,
    parameter int         IDX_W       = 3,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    i2c_regbank_target_if.slave   bus,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  wr_pulse,
    output logic [IDX_W-1:0]      wr_idx,
    output logic                  busy
);
    // IDLE:bus free  ADDR/SUB/WDAT:shift in byte  *_ACK:drive ACK for one SCL period
    // RDAT:shift out byte  RDAT_ACK:release SDA, sample master ACK/NAK  WAIT:ignore until START/STOP
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK, WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] sda_sync_q, scl_sync_q;
    logic                   sda_s, scl_s, sda_p_q, scl_p_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sda_sync_q <= '1;
            scl_sync_q <= '1;
        end else begin
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] sda_hist_q, scl_hist_q;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sda_hist_q <= '1;
            scl_hist_q <= '1;
        end else begin
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[SYNC_STAGES-1]};
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[SYNC_STAGES-1]};
        end
    end

    assign sda_s = maj3(sda_sync_q[SYNC_STAGES-1], sda_hist_q[0], sda_hist_q[1]);
    assign scl_s = maj3(scl_sync_q[SYNC_STAGES-1], scl_hist_q[0], scl_hist_q[1]);
`else
    assign sda_s = sda_sync_q[SYNC_STAGES-1];
    assign scl_s = scl_sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sda_p_q <= 1'b1;
            scl_p_q <= 1'b1;
        end else begin
            sda_p_q <= sda_s;
            scl_p_q <= scl_s;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_s & ~scl_p_q;
    assign scl_fall  = ~scl_s & scl_p_q;
    assign start_det = scl_s & scl_p_q & sda_p_q & ~sda_s;
    assign stop_det  = scl_s & scl_p_q & ~sda_p_q & sda_s;

    state_t           state_q;
    logic [2:0]       bit_cnt_q;
    logic [6:0]       shift_q;
    logic [IDX_W-1:0] ptr_q;
    logic [7:0]       regs_q [NUM_REGS];
    logic             sda_oe_q, wr_pulse_q, busy_q, rw_q, ack_ph_q;
    logic [IDX_W-1:0] wr_idx_q;
    logic [7:0]       byte_in;

    assign byte_in = {shift_q, sda_s};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            ack_ph_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_pulse_q <= 1'b0;
            if (start_det) begin
                state_q   <= ADDR;
                bit_cnt_q <= '0;
                busy_q    <= 1'b1;
            end else if (stop_det) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else if (scl_rise) begin
                case (state_q)
                    ADDR, SUB, WDAT: begin
                        shift_q   <= byte_in[6:0];
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ack_ph_q <= 1'b0;
                            case (state_q)
                                ADDR: begin
                                    if (byte_in[7:1] == I2C_ADDR) begin
                                        rw_q    <= byte_in[0];
                                        state_q <= ADDR_ACK;
                                    end else begin
                                        state_q <= WAIT;
                                        busy_q  <= 1'b0;
                                    end
                                end
                                SUB: begin
                                    ptr_q   <= byte_in[IDX_W-1:0];
                                    state_q <= SUB_ACK;
                                end
                                default: begin
                                    regs_q[ptr_q] <= byte_in;
                                    wr_pulse_q    <= 1'b1;
                                    wr_idx_q      <= ptr_q;
                                    state_q       <= WDAT_ACK;
                                end
                            endcase
                        end
                    end
                    RDAT: begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ptr_q    <= ptr_q + 1'b1;
                            ack_ph_q <= 1'b0;
                            state_q  <= RDAT_ACK;
                        end
                    end
                    RDAT_ACK: begin
                        if (ack_ph_q && sda_s) begin
                            state_q <= WAIT;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state_q)
                    ADDR_ACK, SUB_ACK, WDAT_ACK: begin
                        if (!ack_ph_q) begin
                            sda_oe_q <= 1'b1;
                            ack_ph_q <= 1'b1;
                        end else begin
                            ack_ph_q  <= 1'b0;
                            bit_cnt_q <= '0;
                            case (state_q)
                                ADDR_ACK: begin
                                    if (rw_q) begin
                                        shift_q  <= regs_q[ptr_q][6:0];
                                        sda_oe_q <= ~regs_q[ptr_q][7];
                                        state_q  <= RDAT;
                                    end else begin
                                        sda_oe_q <= 1'b0;
                                        state_q  <= SUB;
                                    end
                                end
                                SUB_ACK: begin
                                    sda_oe_q <= 1'b0;
                                    state_q  <= WDAT;
                                end
                                default: begin
                                    sda_oe_q <= 1'b0;
                                    ptr_q    <= ptr_q + 1'b1;
                                    state_q  <= WDAT;
                                end
                            endcase
                        end
                    end
                    RDAT: begin
                        sda_oe_q <= ~shift_q[6];
                        shift_q  <= {shift_q[5:0], 1'b0};
                    end
                    RDAT_ACK: begin
                        if (!ack_ph_q) begin
                            sda_oe_q <= 1'b0;
                            ack_ph_q <= 1'b1;
                        end else begin
                            // Master ACKed: reload the shifter exactly once for the next byte.
                            shift_q   <= regs_q[ptr_q][6:0];
                            sda_oe_q  <= ~regs_q[ptr_q][7];
                            bit_cnt_q <= '0;
                            state_q   <= RDAT;
                        end
                    end
                    default: sda_oe_q <= 1'b0;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs_q[g];
    end

    assign bus.sda_out = 1'b0;
    assign bus.sda_oe  = sda_oe_q;
    assign wr_pulse    = wr_pulse_q;
    assign wr_idx      = wr_idx_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_i2c_regbank_target.sv
// Directed bench for i2c_regbank_target: open-drain bus model, bit-banged master, hand-computed expectations.
module tb_i2c_regbank_target;
    localparam int Q = 8;
`ifdef I2C_GLITCH_FILTER_EN
    localparam logic FILT = 1'b1;
`else
    localparam logic FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic [63:0] regs_flat;
    logic        wr_pulse;
    logic [2:0]  wr_idx;
    logic        busy;
    int          n_chk = 0;
    int          n_err = 0;
    logic [2:0]  wr_log[$];
    logic        oe_seen = 1'b0;

    i2c_regbank_target_if bus();
    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & (bus.sda_oe ? bus.sda_out : 1'b1);

    i2c_regbank_target #(.I2C_ADDR(7'h70), .NUM_REGS(8), .IDX_W(3), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .regs_flat (regs_flat),
        .wr_pulse  (wr_pulse),
        .wr_idx    (wr_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_pulse) wr_log.push_back(wr_idx);
        if (bus.sda_oe) oe_seen = 1'b1;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] reg_at(input int i);
        return regs_flat[8*i +: 8];
    endfunction

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        ack = ~bus.sda_in;
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic read_byte(input logic last, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wait_q();
            scl_m = 1'b1; wait_q();
            d[i] = bus.sda_in;
            wait_q();
            scl_m = 1'b0; wait_q();
        end
        send_bit(last);
    endtask

    logic       ack;
    logic [7:0] rd;
    logic [7:0] d1 [4]     = '{8'hAA, 8'h55, 8'h69, 8'h96};
    logic [7:0] rd_exp [8] = '{8'hAA, 8'h55, 8'h69, 8'h96, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] d3 [4]     = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [63:0] snap;

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_sda_oe", bus.sda_oe, 1'b0);
        chk("rst_regs", regs_flat, 64'h0);
        chk("rst_wr_pulse", wr_pulse, 1'b0);
        chk("rst_wr_idx", wr_idx, 3'd0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Write AA 55 69 96 from sub-address 0
        wr_log.delete();
        i2c_start();
        chk("w1_busy_start", busy, 1'b1);
        write_byte(8'hE0, ack); chk("w1_ack_addr", ack, 1'b1);
        write_byte(8'h00, ack); chk("w1_ack_sub", ack, 1'b1);
        for (int i = 0; i < 4; i++) begin
            write_byte(d1[i], ack);
            chk($sformatf("w1_ack_d%0d", i), ack, 1'b1);
        end
        i2c_stop();
        chk("w1_busy_stop", busy, 1'b0);
        chk("w1_regs", regs_flat, 64'h0000_0000_9669_55AA);
        chk("w1_wr_cnt", wr_log.size(), 4);
        for (int i = 0; i < wr_log.size() && i < 4; i++)
            chk($sformatf("w1_wr_idx%0d", i), wr_log[i], i);

        // Sub 0, repeated START, read 8 bytes
        i2c_start();
        write_byte(8'hE0, ack); chk("r1_ack_addr", ack, 1'b1);
        write_byte(8'h00, ack); chk("r1_ack_sub", ack, 1'b1);
        i2c_start();
        write_byte(8'hE1, ack); chk("r1_ack_raddr", ack, 1'b1);
        for (int i = 0; i < 8; i++) begin
            read_byte(i == 7, rd);
            chk($sformatf("r1_byte%0d", i), rd, rd_exp[i]);
        end
        chk("r1_oe_after_nak", bus.sda_oe, 1'b0);
        chk("r1_busy_after_nak", busy, 1'b0);
        i2c_stop();

        // Wrapping write from sub-address 6
        i2c_start();
        write_byte(8'hE0, ack); chk("w2_ack_addr", ack, 1'b1);
        write_byte(8'h06, ack); chk("w2_ack_sub", ack, 1'b1);
        for (int i = 0; i < 4; i++) begin
            write_byte(d3[i], ack);
            chk($sformatf("w2_ack_d%0d", i), ack, 1'b1);
        end
        i2c_stop();
        chk("w2_regs", regs_flat, 64'h2211_0000_9669_4433);

        // Pointer persists across STOP: 6+4 wraps to 2
        i2c_start();
        write_byte(8'hE1, ack); chk("r2_ack_addr", ack, 1'b1);
        read_byte(1'b1, rd);
        chk("r2_resume_byte", rd, 8'h69);
        i2c_stop();

        // Foreign address: no ACK, no writes, busy drops
        snap = 64'h2211_0000_9669_4433;
        oe_seen = 1'b0;
        i2c_start();
        write_byte(8'hD0, ack); chk("na_ack_addr", ack, 1'b0);
        chk("na_busy", busy, 1'b0);
        write_byte(8'h12, ack); chk("na_ack_d0", ack, 1'b0);
        write_byte(8'h34, ack); chk("na_ack_d1", ack, 1'b0);
        chk("na_busy_late", busy, 1'b0);
        i2c_stop();
        chk("na_oe_seen", oe_seen, 1'b0);
        chk("na_regs", regs_flat, snap);

        // Reset pulse during the 5th data bit
        i2c_start();
        write_byte(8'hE0, ack); chk("rs_ack_addr", ack, 1'b1);
        write_byte(8'h00, ack); chk("rs_ack_sub", ack, 1'b1);
        for (int i = 7; i >= 4; i--) send_bit(d1[0][i]);
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rs_sda_oe", bus.sda_oe, 1'b0);
        chk("rs_regs", regs_flat, 64'h0);
        chk("rs_busy", busy, 1'b0);
        rst_n = 1'b1;
        wait_q();
        scl_m = 1'b0; wait_q();
        i2c_stop();
        wr_log.delete();
        i2c_start();
        write_byte(8'hE0, ack); chk("rs2_ack_addr", ack, 1'b1);
        write_byte(8'h01, ack); chk("rs2_ack_sub", ack, 1'b1);
        write_byte(8'h5A, ack); chk("rs2_ack_d0", ack, 1'b1);
        write_byte(8'hC3, ack); chk("rs2_ack_d1", ack, 1'b1);
        i2c_stop();
        chk("rs2_regs", regs_flat, 64'h0000_0000_00C3_5A00);
        chk("rs2_wr_cnt", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("rs2_wr_idx0", wr_log[0], 3'd1);
            chk("rs2_wr_idx1", wr_log[1], 3'd2);
        end

        // 1-clk SCL spike before the sub-address byte 0x02
        i2c_start();
        write_byte(8'hE0, ack); chk("gl_ack_addr", ack, 1'b1);
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; @(negedge clk);
        scl_m = 1'b0; wait_q();
        write_byte(8'h02, ack);
        chk("gl_ack_sub", ack, FILT ? 1'b1 : 1'b0);
        i2c_stop();
        chk("gl_regs", regs_flat, 64'h0000_0000_00C3_5A00);
        i2c_start();
        write_byte(8'hE1, ack); chk("gl_ack_raddr", ack, 1'b1);
        read_byte(1'b1, rd);
        chk("gl_ptr_byte", rd, FILT ? 8'hC3 : 8'h5A);
        i2c_stop();

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
